exc_stack_frame_ctrl: RTL and testbench
=======================================

// Module: exc_stack_frame_ctrl
// PURPOSE
//  Exception context stacker: on entry pushes an N-word frame below the active SP (MSP or PSP).
//  On return pops the frame and hands words back to the register file.
//  Writes the adjusted SP back to the banked-SP block; sits between core control and the data bus.
// PARAMETERS
//  FRAME_WORDS  8   words per frame (R0-R3,R12,LR,PC,xPSR order, lowest address first)
//  AW           32  address width / SP width
//  DW           32  data width
// PORTS
//  clk            in   1            clock
//  rst            in   1            reset, asynchronous, active-high
//  entry_req      in   1            start push (sampled in IDLE only)
//  return_req     in   1            start pop (sampled in IDLE only)
//  use_psp        in   1            1: operate on psp_in, 0: msp_in (latched at start)
//  msp_in/psp_in  in   AW each      current banked stack pointers
//  stack_limit    in   AW           lowest legal SP (used only with STACK_LIMIT_CHK_EN)
//  ctx_in         in   FRAME_WORDS*DW  context to push, word i at [i*DW+:DW]
//  mem_req        out  1            bus request, held until mem_ack
//  mem_we         out  1            1 write (push), 0 read (pop)
//  mem_addr       out  AW           word address (bits[1:0]=0)
//  mem_wdata      out  DW           push data
//  mem_rdata      in   DW           pop data, valid with mem_ack
//  mem_ack        in   1            transfer complete this cycle (may be same cycle as mem_req)
//  restore_valid  out  1            one-cycle strobe: restore_data for word restore_idx
//  restore_idx    out  $clog2(FRAME_WORDS)  popped word index
//  restore_data   out  DW           popped word
//  sp_wr_en       out  1            one-cycle strobe: write sp_wdata to bank sp_sel
//  sp_sel         out  1            0 MSP, 1 PSP
//  sp_wdata       out  AW           new SP
//  busy/done/fault out 1 each       busy: state!=IDLE; done/fault: one-cycle pulses
// BEHAVIOUR
//  - Reset: state IDLE, every output 0; reset mid-operation aborts and drops mem_req at once.
//  - FSM: IDLE -> PUSH|POP -> UPDATE -> IDLE; IDLE -> FAULT -> IDLE.
//  - Both reqs in IDLE: entry wins, return dropped. Reqs outside IDLE ignored, not queued.
//  - Start: SP latched; SP[1:0]!=0 -> FAULT: fault pulse next cycle, no bus access, SP untouched.
//  - PUSH: base=SP-4*FRAME_WORDS (mod 2^AW); word i written at base+4*i, i=0..N-1.
//    mem_addr/mem_wdata stable while mem_req high.
//  - POP: word i read at SP+4*i; ack cycle -> restore_valid=1, restore_idx=i, restore_data=mem_rdata.
//  - Words go in ascending i; the next request is issued the cycle after each ack.
//  - UPDATE: sp_wr_en=1, done=1 for one cycle. sp_wdata=base (push) or SP+4*FRAME_WORDS mod 2^AW (pop).
//  - Latency (zero-wait ack): req cycle 0; mem_req cycles 1..N; sp_wr_en/done in cycle N+1.
//  - Wait states stretch a word; the FSM never times out.
//  - Address wrap: arithmetic is modulo 2^AW and otherwise unflagged when the limit check is off.
// CONFIGURATION
//  STACK_LIMIT_CHK_EN defined: on entry, fault when base < stack_limit (unsigned) or SP-4*N borrows.
//   The fault occurs before any write. Pop is unchecked.
//  Undefined: stack_limit ignored; only misalignment faults.
// STRUCTURE
//  Package exc_stack_pkg: state enum, FRAME_BYTES, SP_SEL_MSP/SP_SEL_PSP.
//  Sub-module stack_addr_gen (combinational):
//   base/next-SP, alignment and limit checks, word-address generation.
// TESTING
//  1 SP=MSP=0x200, zero-wait push -> writes 0x1E0..0x1FC ctx0..ctx7, sp_wdata=0x1E0 sp_sel=0, done cycle 9
//  2 Pop from PSP=0x1E0, 2 wait states/word -> 8 restore strobes idx 0..7, sp_wdata=0x200 sp_sel=1
//  3 SP=0x202 entry -> fault pulse, mem_req never asserted, no sp_wr_en
//  4 entry_req+return_req together in IDLE -> push only; return_req during PUSH ignored
//  5 rst asserted after 3rd push ack -> mem_req/busy 0 immediately; no sp_wr_en
//  6 LIMIT_EN: SP=0x110 limit=0x100 -> fault; without macro -> push to 0xF0

Source files
------------

// File: rtl/exc_stack_pkg.sv
// Shared constants for the exception stack-frame controller: FSM encodings, frame size and
// banked-SP selector values.
package exc_stack_pkg;

  localparam int unsigned WORD_BYTES  = 4;
  // Byte size of the default 8-word frame (R0-R3, R12, LR, PC, xPSR)
  localparam int unsigned FRAME_BYTES = WORD_BYTES * 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PUSH   = 3'd1;
  localparam logic [2:0] ST_POP    = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  localparam logic SP_SEL_MSP = 1'b0;
  localparam logic SP_SEL_PSP = 1'b1;

  // Frame size in bytes for an arbitrary word count
  function automatic int unsigned frame_bytes(input int unsigned words);
    return WORD_BYTES * words;
  endfunction

endpackage

// File: rtl/stack_addr_gen.sv
// Combinational address/SP arithmetic for the stack-frame controller: start-of-operation
// alignment and limit checks, per-word bus address and the SP value written back.
// Optional feature macro: STACK_LIMIT_CHK_EN (entry-side stack limit check).
module stack_addr_gen
  import exc_stack_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 8,
  parameter int unsigned AW          = 32,
  parameter int unsigned IW          = 3
) (
  input  logic [AW-1:0] start_sp_i,
  input  logic [AW-1:0] stack_limit_i,
  input  logic [AW-1:0] sp_i,
  input  logic [IW-1:0] idx_i,
  input  logic          push_i,
  output logic          misaligned_o,
  output logic          entry_fault_o,
  output logic [AW-1:0] addr_o,
  output logic [AW-1:0] new_sp_o
);

  localparam logic [AW-1:0] FrameSz = AW'(frame_bytes(FRAME_WORDS));

  logic [AW-1:0] push_base;
  logic [AW-1:0] word_off;

  assign misaligned_o = |start_sp_i[1:0];

`ifdef STACK_LIMIT_CHK_EN
  logic [AW-1:0] start_base;
  logic          borrow;
  logic          limit_fault;

  // Entry faults if the frame would dip below the limit or wrap under address zero
  always_comb begin
    start_base  = start_sp_i - FrameSz;
    borrow      = start_sp_i < FrameSz;
    limit_fault = borrow | (start_base < stack_limit_i);
  end

  assign entry_fault_o = misaligned_o | limit_fault;
`else
  logic unused_stack_limit;
  assign unused_stack_limit = ^stack_limit_i;
  assign entry_fault_o      = misaligned_o;
`endif

  // Word address and written-back SP from the SP latched at operation start
  always_comb begin
    push_base = sp_i - FrameSz;
    word_off  = AW'({idx_i, 2'b00});
    addr_o    = (push_i ? push_base : sp_i) + word_off;
    new_sp_o  = push_i ? push_base : (sp_i + FrameSz);
  end

endmodule

// File: rtl/exc_stack_frame_ctrl.sv
// Exception context stacker: pushes an N-word frame below the active SP on entry, pops it
// back to the register file on return, then writes the adjusted SP to the banked-SP block.
// Optional feature macro: STACK_LIMIT_CHK_EN (handled in stack_addr_gen).
module exc_stack_frame_ctrl
  import exc_stack_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 8,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  localparam int unsigned IW         = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      entry_req,
  input  logic                      return_req,
  input  logic                      use_psp,
  input  logic [AW-1:0]             msp_in,
  input  logic [AW-1:0]             psp_in,
  input  logic [AW-1:0]             stack_limit,
  input  logic [FRAME_WORDS*DW-1:0] ctx_in,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_wdata,
  input  logic [DW-1:0]             mem_rdata,
  input  logic                      mem_ack,
  output logic                      restore_valid,
  output logic [IW-1:0]             restore_idx,
  output logic [DW-1:0]             restore_data,
  output logic                      sp_wr_en,
  output logic                      sp_sel,
  output logic [AW-1:0]             sp_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      fault
);

  logic [2:0]                state_q, state_d;
  logic [AW-1:0]             sp_q, sp_d;
  logic                      sel_q, sel_d;
  logic                      push_q, push_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [FRAME_WORDS*DW-1:0] ctx_q, ctx_d;

  logic [AW-1:0] start_sp;
  logic          misaligned;
  logic          entry_fault;
  logic [AW-1:0] word_addr;
  logic [AW-1:0] new_sp;
  logic [DW-1:0] wdata_word;
  logic          in_xfer;

  assign start_sp = use_psp ? psp_in : msp_in;

  stack_addr_gen #(
    .FRAME_WORDS (FRAME_WORDS),
    .AW          (AW),
    .IW          (IW)
  ) u_addr_gen (
    .start_sp_i    (start_sp),
    .stack_limit_i (stack_limit),
    .sp_i          (sp_q),
    .idx_i         (idx_q),
    .push_i        (push_q),
    .misaligned_o  (misaligned),
    .entry_fault_o (entry_fault),
    .addr_o        (word_addr),
    .new_sp_o      (new_sp)
  );

  // Next-state: accept a request in IDLE, step one word per ack, then update/fault and idle
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    sel_d   = sel_q;
    push_d  = push_q;
    idx_d   = idx_q;
    ctx_d   = ctx_q;
    case (state_q)
      ST_IDLE: begin
        if (entry_req || return_req) begin
          // Entry wins over a simultaneous return
          sp_d   = start_sp;
          sel_d  = use_psp;
          push_d = entry_req;
          idx_d  = '0;
          if (entry_req) begin
            ctx_d = ctx_in;
          end
          if (entry_req ? entry_fault : misaligned) begin
            state_d = ST_FAULT;
          end else begin
            state_d = entry_req ? ST_PUSH : ST_POP;
          end
        end
      end
      ST_PUSH, ST_POP: begin
        if (mem_ack) begin
          if (idx_q == IW'(FRAME_WORDS - 1)) begin
            state_d = ST_UPDATE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_UPDATE, ST_FAULT: state_d = ST_IDLE;
      default:             state_d = ST_IDLE;
    endcase
  end

  // State registers; asynchronous reset aborts any operation immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sp_q    <= '0;
      sel_q   <= SP_SEL_MSP;
      push_q  <= 1'b0;
      idx_q   <= '0;
      ctx_q   <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      sel_q   <= sel_d;
      push_q  <= push_d;
      idx_q   <= idx_d;
      ctx_q   <= ctx_d;
    end
  end

  // Select the latched context word for the current push index
  always_comb begin
    wdata_word = '0;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      if (idx_q == IW'(i)) begin
        wdata_word = ctx_q[i*DW +: DW];
      end
    end
  end

  // Outputs decoded from state; data/address buses held at zero when not meaningful
  always_comb begin
    in_xfer       = (state_q == ST_PUSH) || (state_q == ST_POP);
    busy          = state_q != ST_IDLE;
    mem_req       = in_xfer;
    mem_we        = state_q == ST_PUSH;
    mem_addr      = in_xfer ? word_addr : '0;
    mem_wdata     = (state_q == ST_PUSH) ? wdata_word : '0;
    restore_valid = (state_q == ST_POP) && mem_ack;
    restore_idx   = restore_valid ? idx_q : '0;
    restore_data  = restore_valid ? mem_rdata : '0;
    sp_wr_en      = state_q == ST_UPDATE;
    done          = state_q == ST_UPDATE;
    sp_sel        = (state_q == ST_UPDATE) ? sel_q : SP_SEL_MSP;
    sp_wdata      = (state_q == ST_UPDATE) ? new_sp : '0;
    fault         = state_q == ST_FAULT;
  end

endmodule

// File: tb/tb_exc_stack_frame_ctrl.sv
// Self-checking bench for exc_stack_frame_ctrl: directed vector table, randomized operations
// against a frame-level reference model, and a mid-push reset sequence.
module tb_exc_stack_frame_ctrl;

  localparam int unsigned FW = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic           clk;
  logic           rst;
  logic           entry_req;
  logic           return_req;
  logic           use_psp;
  logic [AW-1:0]  msp_in;
  logic [AW-1:0]  psp_in;
  logic [AW-1:0]  stack_limit;
  logic [FW*DW-1:0] ctx_in;
  logic           mem_req;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic           mem_ack;
  logic           restore_valid;
  logic [2:0]     restore_idx;
  logic [DW-1:0]  restore_data;
  logic           sp_wr_en;
  logic           sp_sel;
  logic [AW-1:0]  sp_wdata;
  logic           busy;
  logic           done;
  logic           fault;

  int    checks = 0;
  int    errors = 0;
  string cur_tag = "";
  logic [31:0] ctx [FW];

  exc_stack_frame_ctrl #(
    .FRAME_WORDS (FW),
    .AW          (AW),
    .DW          (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .entry_req     (entry_req),
    .return_req    (return_req),
    .use_psp       (use_psp),
    .msp_in        (msp_in),
    .psp_in        (psp_in),
    .stack_limit   (stack_limit),
    .ctx_in        (ctx_in),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .restore_valid (restore_valid),
    .restore_idx   (restore_idx),
    .restore_data  (restore_data),
    .sp_wr_en      (sp_wr_en),
    .sp_sel        (sp_sel),
    .sp_wdata      (sp_wdata),
    .busy          (busy),
    .done          (done),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          ent;
    bit          ret;
    bit          psp;
    logic [31:0] msp_v;
    logic [31:0] psp_v;
    logic [31:0] lim;
    int          ws;
    bit          ret_during;
    bit          exp_fault;
    logic [31:0] exp_sp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s %s got=%0h expected=%0h", cur_tag, n, got, exp);
    end
  endtask

  // Memory contents seen by pops: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_5A3C;
  endfunction

  // Reference model: frame rules at the operation level
  function automatic bit model_fault(input bit ent, input logic [31:0] sp, input logic [31:0] lim);
    longint b;
    b = longint'(sp) - 32;
    if (sp[1:0] != 2'b00) return 1'b1;
    if (!ent) return 1'b0;
`ifdef STACK_LIMIT_CHK_EN
    if (b < 0 || b < longint'(lim)) return 1'b1;
`else
    if (b < 0 && lim == 32'h1) return 1'b0;  // limit ignored in this build
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_sp(input bit ent, input logic [31:0] sp);
    longint r;
    r = ent ? (longint'(sp) - 32) : (longint'(sp) + 32);
    return 32'(r & 64'hFFFF_FFFF);
  endfunction

  function automatic void add_vec(input bit ent, input bit ret, input bit psp,
                                  input logic [31:0] msp_v, input logic [31:0] psp_v,
                                  input logic [31:0] lim, input int ws, input bit ret_during,
                                  input bit exp_fault, input logic [31:0] exp_sp,
                                  input string name);
    vec_t v;
    v.ent = ent; v.ret = ret; v.psp = psp; v.msp_v = msp_v; v.psp_v = psp_v; v.lim = lim;
    v.ws = ws; v.ret_during = ret_during; v.exp_fault = exp_fault; v.exp_sp = exp_sp;
    v.name = name;
    vecs.push_back(v);
  endfunction

  // One complete operation with a wait-state memory responder; starts just after a negedge
  task automatic run_op(input bit ent, input bit ret, input bit psp, input logic [31:0] msp_v,
                        input logic [31:0] psp_v, input logic [31:0] lim, input int ws,
                        input bit ret_during, input bit exp_fault, input logic [31:0] exp_sp);
    logic [31:0] sp;
    logic [31:0] base;
    logic [31:0] exp_addr;
    bit          is_push;
    bit          got_done;
    bit          got_fault;
    bit          saw_req;
    int          words;
    int          wcnt;
    int          cyc;
    int          done_cyc;
    sp       = psp ? psp_v : msp_v;
    is_push  = ent;
    base     = is_push ? sp - 32'd32 : sp;
    use_psp  = psp;
    msp_in   = msp_v;
    psp_in   = psp_v;
    stack_limit = lim;
    for (int i = 0; i < FW; i++) begin
      ctx[i] = $urandom;
      ctx_in[i*DW +: DW] = ctx[i];
    end
    entry_req  = ent;
    return_req = ret;
    got_done = 0; got_fault = 0; saw_req = 0;
    words = 0; wcnt = 0; cyc = 0; done_cyc = 0;
    while (!got_done && !got_fault && cyc < 300) begin
      @(negedge clk);
      cyc++;
      mem_ack    = 1'b0;
      entry_req  = 1'b0;
      return_req = ret_during;
      #1;
      if (mem_req) begin
        saw_req  = 1;
        exp_addr = base + 32'(4 * words);
        chk("mem_we", 64'(mem_we), 64'(is_push));
        chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
        if (is_push && words < FW) chk("mem_wdata", 64'(mem_wdata), 64'(ctx[words]));
        if (wcnt == ws) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          #1;
          chk("restore_valid", 64'(restore_valid), 64'(!is_push));
          if (!is_push) begin
            chk("restore_idx", 64'(restore_idx), 64'(words));
            chk("restore_data", 64'(restore_data), 64'(mem_word(exp_addr)));
          end
          words++;
          wcnt = 0;
        end else begin
          chk("restore_valid_idle", 64'(restore_valid), 64'd0);
          wcnt++;
        end
      end
      if (sp_wr_en) begin
        got_done   = 1;
        done_cyc   = cyc;
        return_req = 1'b0;
        chk("done", 64'(done), 64'd1);
        chk("sp_wdata", 64'(sp_wdata), 64'(exp_sp));
        chk("sp_sel", 64'(sp_sel), 64'(psp));
      end
      if (fault) got_fault = 1;
    end
    mem_ack = 1'b0;
    return_req = 1'b0;
    if (cyc >= 300) chk("timeout", 64'd1, 64'd0);
    chk("fault", 64'(got_fault), 64'(exp_fault));
    if (exp_fault) begin
      chk("fault_cycle", 64'(cyc), 64'd1);
      chk("no_bus_on_fault", 64'(saw_req), 64'd0);
      chk("no_sp_wr_on_fault", 64'(got_done), 64'd0);
    end else begin
      chk("word_count", 64'(words), 64'(FW));
      chk("done_cycle", 64'(done_cyc), 64'(1 + FW * (ws + 1)));
    end
    // Back to IDLE and nothing queued from requests seen while busy
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_mem_req", 64'(mem_req), 64'd0);
    end
  endtask

  initial begin
    bit          r_ent;
    bit          r_ret;
    bit          r_psp;
    logic [31:0] r_sp;
    logic [31:0] r_other;
    logic [31:0] r_lim;
    int          r_ws;
    int          acks;
    int          cyc;
    bit          lim_on;

`ifdef STACK_LIMIT_CHK_EN
    lim_on = 1;
`else
    lim_on = 0;
`endif

    clk = 0; rst = 1;
    entry_req = 0; return_req = 0; use_psp = 0;
    msp_in = '0; psp_in = '0; stack_limit = '0; ctx_in = '0;
    mem_rdata = '0; mem_ack = 0;

    #12;
    cur_tag = "reset";
    chk("busy", 64'(busy), 64'd0);
    chk("mem_req", 64'(mem_req), 64'd0);
    chk("mem_addr", 64'(mem_addr), 64'd0);
    chk("sp_wr_en", 64'(sp_wr_en), 64'd0);
    chk("done", 64'(done), 64'd0);
    chk("fault", 64'(fault), 64'd0);
    chk("restore_valid", 64'(restore_valid), 64'd0);
    chk("sp_wdata", 64'(sp_wdata), 64'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // ent ret psp msp psp lim ws ret_during exp_fault exp_sp name
    add_vec(1, 0, 0, 32'h200, 32'h0, 32'h0, 0, 0, 0, 32'h1E0, "push_msp_zero_wait");
    add_vec(0, 1, 1, 32'h0, 32'h1E0, 32'h0, 2, 0, 0, 32'h200, "pop_psp_two_waits");
    add_vec(1, 0, 0, 32'h202, 32'h0, 32'h0, 0, 0, 1, 32'h0, "push_misaligned");
    add_vec(1, 1, 0, 32'h300, 32'h0, 32'h0, 1, 1, 0, 32'h2E0, "both_reqs_entry_wins");
    add_vec(1, 0, 0, 32'h110, 32'h0, 32'h100, 0, 0, lim_on, lim_on ? 32'h0 : 32'hF0,
            "limit_below");
    add_vec(1, 0, 1, 32'h0, 32'h10, 32'h0, 0, 0, lim_on, lim_on ? 32'h0 : 32'hFFFF_FFF0,
            "push_borrow_wrap");
    add_vec(0, 1, 0, 32'hFFFF_FFF0, 32'h0, 32'h0, 1, 0, 0, 32'h10, "pop_wrap");
    add_vec(0, 1, 1, 32'h0, 32'h1E1, 32'h0, 0, 0, 1, 32'h0, "pop_misaligned");
    add_vec(1, 0, 0, 32'h120, 32'h0, 32'h100, 0, 0, 0, 32'h100, "limit_exact");
    add_vec(0, 1, 0, 32'h80, 32'h0, 32'h1000, 0, 0, 0, 32'hA0, "pop_unchecked_limit");

    foreach (vecs[k]) begin
      cur_tag = vecs[k].name;
      run_op(vecs[k].ent, vecs[k].ret, vecs[k].psp, vecs[k].msp_v, vecs[k].psp_v, vecs[k].lim,
             vecs[k].ws, vecs[k].ret_during, vecs[k].exp_fault, vecs[k].exp_sp);
    end

    for (int n = 0; n < 30; n++) begin
      cur_tag = $sformatf("rnd%0d", n);
      r_ent   = 1'($urandom_range(0, 1));
      r_ret   = !r_ent || ($urandom_range(0, 3) == 0);
      r_psp   = 1'($urandom_range(0, 1));
      r_sp    = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) r_sp[1:0] = 2'($urandom_range(1, 3));
      r_lim   = $urandom & 32'h0000_0FFC;
      r_other = $urandom;
      r_ws    = $urandom_range(0, 2);
      run_op(r_ent, r_ret, r_psp, r_psp ? r_other : r_sp, r_psp ? r_sp : r_other, r_lim, r_ws, 0,
             model_fault(r_ent, r_sp, r_lim), model_sp(r_ent, r_sp));
    end

    // Reset after the third push ack: bus request and busy must drop at once
    cur_tag = "reset_mid_push";
    use_psp = 0; msp_in = 32'h400; stack_limit = '0;
    entry_req = 1;
    acks = 0; cyc = 0;
    while (acks < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      entry_req = 0;
      mem_ack = 0;
      #1;
      if (mem_req) begin
        mem_ack = 1;
        acks++;
      end
    end
    chk("acks_before_reset", 64'(acks), 64'd3);
    @(negedge clk);
    mem_ack = 0;
    #1;
    chk("pre_reset_mem_req", 64'(mem_req), 64'd1);
    rst = 1;
    #1;
    chk("mem_req_after_rst", 64'(mem_req), 64'd0);
    chk("busy_after_rst", 64'(busy), 64'd0);
    chk("sp_wr_en_after_rst", 64'(sp_wr_en), 64'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("sp_wr_en_in_rst", 64'(sp_wr_en), 64'd0);
      chk("done_in_rst", 64'(done), 64'd0);
    end
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("sp_wr_en_post_rst", 64'(sp_wr_en), 64'd0);
      chk("busy_post_rst", 64'(busy), 64'd0);
    end
    cur_tag = "push_after_reset";
    run_op(1, 0, 0, 32'h400, 32'h0, 32'h0, 0, 0, 0, 32'h3E0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
